// File: rtl/slider_switch_debouncer_if.sv
// Switch-conditioning bundle: raw pins in, debounced level and change strobes out.
interface slider_switch_debouncer_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_changed;
  logic             sw_changed_any;

  modport master (
    output sw_raw,
    input  sw_out,
    input  sw_changed,
    input  sw_changed_any
  );

  modport slave (
    input  sw_raw,
    output sw_out,
    output sw_changed,
    output sw_changed_any
  );
endinterface

// File: rtl/slider_switch_debouncer.sv
// Slider switch conditioner: per-bit 2-FF synchroniser followed by a tick-sampled
// stability filter that accepts a new level after STABLE_TICKS consecutive differing ticks.
module slider_switch_debouncer #(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 500,
  parameter int STABLE_TICKS = 500
) (
  input  logic                       clk,
  input  logic                       reset,
  slider_switch_debouncer_if.slave   sw
);
  localparam int              TW        = $clog2(TICK_DIV);
  localparam int              CW        = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_p0_q;
  logic [WIDTH-1:0] sync_p1_q;
  logic [TW-1:0]    tcnt_q;
  logic [TW-1:0]    tcnt_d;
  logic             tick;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] chg_d;
  logic             any_q;

  // Stage p0/p1: two-flop synchroniser on the asynchronous pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0_q <= '0;
      sync_p1_q <= '0;
    end else begin
      sync_p0_q <= sw.sw_raw;
      sync_p1_q <= sync_p0_q;
    end
  end

  assign tick   = (tcnt_q == TICK_LAST);
  assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

  // Stage p2: filter; any cycle of agreement clears the count, ticks advance it
  always_comb begin
    out_d = out_q;
    chg_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_p1_q[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          out_d[i] = sync_p1_q[i];
          chg_d[i] = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
      out_q  <= '0;
      chg_q  <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      out_q  <= out_d;
      chg_q  <= chg_d;
      any_q  <= |chg_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw.sw_out         = out_q;
  assign sw.sw_changed     = chg_q;
  assign sw.sw_changed_any = any_q;
endmodule

// File: tb/tb_slider_switch_debouncer.sv
// Bench for slider_switch_debouncer: directed scenarios plus random stimulus against a tick-arithmetic model.
module tb_slider_switch_debouncer;
  localparam int W  = 10;
  localparam int TD = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slider_switch_debouncer_if #(.WIDTH(W)) sw_if ();

  slider_switch_debouncer #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, last edge each bit agreed with the output.
  logic [W-1:0] m_s1, m_s2, m_out, m_chg;
  int           n;
  int           last_eq [W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Ticks fall on edges n with n % TD == 0; a level is accepted on the
  // ST-th tick counted since the bit last agreed with the output.
  task automatic model_step();
    logic [W-1:0] nxt;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_chg = '0; n = 0;
      for (int i = 0; i < W; i++) last_eq[i] = 0;
    end else begin
      n++;
      nxt   = m_out;
      m_chg = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_out[i]) begin
          last_eq[i] = n;
        end else if ((n % TD == 0) && ((n / TD) - (last_eq[i] / TD) >= ST)) begin
          nxt[i]     = m_s2[i];
          m_chg[i]   = 1'b1;
          last_eq[i] = n;
        end
      end
      m_out = nxt;
      m_s2  = m_s1;
      m_s1  = sw_if.sw_raw;
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sw_out", 32'(sw_if.sw_out), 32'(m_out));
    chk("sw_changed", 32'(sw_if.sw_changed), 32'(m_chg));
    chk("sw_changed_any", 32'(sw_if.sw_changed_any), 32'(|m_chg));
  endtask

  task automatic settle(input int cycles);
    for (int k = 0; k < cycles; k++) cyc1();
  endtask

  int           lat;
  int           pulses;
  int           hold;
  int           ticks;
  logic         act;
  logic [W-1:0] chg_or;

  initial begin
    m_s1 = '0; m_s2 = '0; m_out = '0; m_chg = '0; n = 0;
    for (int i = 0; i < W; i++) last_eq[i] = 0;

    // 1: reset held with all switches high, then release
    @(negedge clk);
    reset = 1'b1;
    sw_if.sw_raw = 10'h3FF;
    for (int k = 0; k < 3; k++) begin
      cyc1();
      chk("t1_out_in_reset", 32'(sw_if.sw_out), 32'h0);
      chk("t1_chg_in_reset", 32'(sw_if.sw_changed), 32'h0);
    end
    reset = 1'b0;
    lat = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc1();
      if (lat < 0 && sw_if.sw_out == 10'h3FF) lat = k;
      if (sw_if.sw_changed != '0) begin
        pulses++;
        chk("t1_pulse_val", 32'(sw_if.sw_changed), 32'h3FF);
        chk("t1_pulse_any", 32'(sw_if.sw_changed_any), 32'h1);
      end
    end
    chk("t1_latency_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    chk("t1_pulse_count", 32'(pulses), 32'h1);

    // 2: clean step on bit 0
    sw_if.sw_raw = '0;
    settle(20);
    chk("t2_cleared", 32'(sw_if.sw_out), 32'h0);
    sw_if.sw_raw = 10'h001;
    lat = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc1();
      if (lat < 0 && sw_if.sw_out[0]) lat = k;
      if (sw_if.sw_changed != '0) begin
        pulses++;
        chk("t2_pulse_val", 32'(sw_if.sw_changed), 32'h001);
      end
    end
    chk("t2_latency_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    chk("t2_pulse_count", 32'(pulses), 32'h1);
    chk("t2_final_out", 32'(sw_if.sw_out), 32'h001);

    // 3: bounce on bit 3 every 5 cycles, then hold high
    act = 1'b0;
    for (int t = 0; t < 8; t++) begin
      sw_if.sw_raw[3] = ~sw_if.sw_raw[3];
      for (int k = 0; k < 5; k++) begin
        cyc1();
        if (sw_if.sw_changed != '0 || sw_if.sw_out[3]) act = 1'b1;
      end
    end
    chk("t3_quiet_while_bouncing", 32'(act), 32'h0);
    sw_if.sw_raw[3] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 18; k++) begin
      cyc1();
      if (lat < 0 && sw_if.sw_out[3]) lat = k;
    end
    chk("t3_latency_le_15", 32'(lat >= 1 && lat <= 15), 32'h1);

    // 4: short glitch on bit 5
    sw_if.sw_raw = '0;
    settle(20);
    chk("t4_start_zero", 32'(sw_if.sw_out), 32'h0);
    sw_if.sw_raw[5] = 1'b1;
    settle(6);
    sw_if.sw_raw[5] = 1'b0;
    act = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc1();
      if (sw_if.sw_out != '0 || sw_if.sw_changed != '0) act = 1'b1;
    end
    chk("t4_glitch_ignored", 32'(act), 32'h0);
    chk("t4_cnt5_cleared", 32'(dut.cnt_q[5]), 32'h0);

    // 5: bits 0 and 9 step together, bit 4 one cycle later
    sw_if.sw_raw = 10'h201;
    cyc1();
    sw_if.sw_raw = 10'h211;
    pulses = 0; chg_or = '0;
    for (int k = 0; k < 20; k++) begin
      cyc1();
      if (sw_if.sw_changed != '0) begin
        pulses++;
        chg_or |= sw_if.sw_changed;
        chk("t5_any_tracks", 32'(sw_if.sw_changed_any), 32'h1);
      end
    end
    chk("t5_pulse_cycles", 32'(pulses == 1 || pulses == 2), 32'h1);
    chk("t5_all_bits_pulsed", 32'(chg_or), 32'h211);
    chk("t5_final_out", 32'(sw_if.sw_out), 32'h211);

    // 6: reset at the second tick of a bit-2 step
    sw_if.sw_raw = '0;
    settle(20);
    sw_if.sw_raw = 10'h004;
    ticks = 0;
    for (int k = 0; k < 2 * TD && ticks < 1; k++) begin
      cyc1();
      if (n % TD == 0) ticks++;
    end
    for (int k = 0; k < TD && ((n + 1) % TD) != 0; k++) cyc1();
    reset = 1'b1;
    cyc1();
    chk("t6_out_in_reset", 32'(sw_if.sw_out), 32'h0);
    chk("t6_no_pulse_reset", 32'(sw_if.sw_changed), 32'h0);
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc1();
      if (lat < 0 && sw_if.sw_out[2]) lat = k;
    end
    chk("t6_latency_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);

    // Random phase: random levels, single-bit flips and occasional reset
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold <= 0) begin
        hold = $urandom_range(1, 14);
        case ($urandom_range(0, 3))
          0:       sw_if.sw_raw = W'($urandom);
          1:       sw_if.sw_raw[$urandom_range(0, W - 1)] = ~sw_if.sw_raw[$urandom_range(0, W - 1)];
          2:       sw_if.sw_raw = ~sw_if.sw_raw;
          default: ;
        endcase
      end
      reset = ($urandom_range(0, 149) == 0);
      cyc1();
      hold--;
    end
    reset = 1'b0;
    settle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
